// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode handshake bundle for the IF/ID queue
interface if_id_queue_if #(parameter int DEPTH = 2);
  logic                         in_valid;
  logic                         in_ready;
  logic [31:0]                  in_pc;
  logic [31:0]                  in_instr;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [31:0]                  out_pc;
  logic [31:0]                  out_instr;
  logic                         out_adel;
  logic [$clog2(DEPTH+1)-1:0]   count;
  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_adel, count
  );
  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_adel, count
  );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode FIFO with AdEL fault tagging and one-cycle flush
module if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter logic [31:0] PC_LIMIT = 32'h0000_6FFC
) (
  input logic         clk,
  input logic         rst,
  if_id_queue_if.slave q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_q [DEPTH];
  logic [31:0]   pc_d [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic          adel_q [DEPTH];
  logic          adel_d [DEPTH];
  logic          push, pop, adel;
  always_comb begin
    q.in_ready  = count_q != CW'(DEPTH);
    q.out_valid = count_q != '0;
    push        = q.in_valid & q.in_ready;
    pop         = q.out_valid & q.out_ready;
    adel        = (q.in_pc[1:0] != 2'b00) | (q.in_pc < PC_BASE) | (q.in_pc > PC_LIMIT);
    pc_d        = pc_q;
    instr_d     = instr_q;
    adel_d      = adel_q;
    if (push) begin
      pc_d[wr_ptr_q]    = q.in_pc;
      instr_d[wr_ptr_q] = adel ? 32'h0 : q.in_instr;
      adel_d[wr_ptr_q]  = adel;
    end
    wr_ptr_d    = q.flush ? '0 : push ? (wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d    = q.flush ? '0 : pop ? (rd_ptr_q == PW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d     = q.flush ? '0 : count_q + CW'(push) - CW'(pop);
    q.out_pc    = q.out_valid ? pc_q[rd_ptr_q] : 32'h0;
    q.out_instr = q.out_valid ? instr_q[rd_ptr_q] : 32'h0;
    q.out_adel  = q.out_valid & adel_q[rd_ptr_q];
    q.count     = count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
  // Storage is never observed while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
    adel_q  <= adel_d;
  end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: scoreboard bench for the IF/ID queue
module tb_if_id_queue;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  ent_t sb[$];
  if_id_queue_if #(.DEPTH(DEPTH)) ifc ();
  if_id_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(ifc.slave));
  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] instr);
    ent_t e;
    e.adel  = (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    e.pc    = pc;
    e.instr = e.adel ? 32'h0 : instr;
    return e;
  endfunction

  function automatic ent_t head();
    ent_t e;
    e = '0;
    if (sb.size() > 0) e = sb[0];
    return e;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic ord, input logic fl);
    bit acc, pp;
    @(negedge clk);
    rst = r; ifc.in_valid = v; ifc.in_pc = pc; ifc.in_instr = instr;
    ifc.out_ready = ord; ifc.flush = fl;
    acc = v && sb.size() < DEPTH;
    pp  = ord && sb.size() > 0;
    @(posedge clk);
    if (r || fl) sb.delete();
    else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(mk(pc, instr));
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h3000, 32'h1, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", ifc.out_valid); end
    tests++; if (ifc.out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", ifc.out_pc); end
    tests++; if (ifc.out_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", ifc.out_instr); end
    tests++; if (ifc.out_adel !== 1'b0) begin fails++; $display("FAIL reset_adel got %0b want 0", ifc.out_adel); end
    tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", ifc.in_ready); end
    tests++; if (ifc.count !== '0) begin fails++; $display("FAIL reset_count got %0d want 0", ifc.count); end
  endtask

  task automatic test_basic();
    drive(0, 1, 32'h3000, 32'h2401_0001, 0, 0);
    tests++; if (ifc.out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b want 1", ifc.out_valid); end
    tests++; if (ifc.out_pc !== 32'h3000) begin fails++; $display("FAIL basic_pc got %h want 3000", ifc.out_pc); end
    tests++; if (ifc.out_instr !== 32'h2401_0001) begin fails++; $display("FAIL basic_instr got %h want 24010001", ifc.out_instr); end
    tests++; if (int'(ifc.count) != 1) begin fails++; $display("FAIL basic_count got %0d want 1", ifc.count); end
    drive(0, 0, 0, 0, 1, 0);
    tests++; if (int'(ifc.count) != sb.size()) begin fails++; $display("FAIL basic_drain got %0d want %0d", ifc.count, sb.size()); end
  endtask

  task automatic test_full();
    drive(0, 1, 32'h3000, 32'hA000_0000, 0, 0);
    drive(0, 1, 32'h3004, 32'hA000_0004, 0, 0);
    tests++; if (int'(ifc.count) != 2) begin fails++; $display("FAIL full_count got %0d want 2", ifc.count); end
    tests++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %0b want 0", ifc.in_ready); end
    drive(0, 1, 32'h3008, 32'hA000_0008, 0, 0);
    tests++; if (int'(ifc.count) != 2) begin fails++; $display("FAIL full_reject got %0d want 2", ifc.count); end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (ifc.out_pc !== 32'h3000 + 32'(4 * i) || ifc.out_pc !== head().pc)
        begin fails++; $display("FAIL full_pop%0d got %h want %h", i, ifc.out_pc, 32'h3000 + 32'(4 * i)); end
      drive(0, 0, 0, 0, 1, 0);
    end
    tests++; if (ifc.count !== '0 || ifc.out_valid !== 1'b0) begin fails++; $display("FAIL full_empty got %0d want 0", ifc.count); end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 32'h3100, 32'hB000_0000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tests++; if (ifc.out_pc !== head().pc) begin fails++; $display("FAIL b2b_pre%0d got %h want %h", i, ifc.out_pc, head().pc); end
      drive(0, 1, 32'h3104 + 32'(4 * i), 32'hB000_0001 + 32'(i), 1, 0);
      tests++; if (int'(ifc.count) != 1) begin fails++; $display("FAIL b2b_count%0d got %0d want 1", i, ifc.count); end
      tests++;
      if (ifc.out_pc !== 32'h3104 + 32'(4 * i) || ifc.out_instr !== head().instr)
        begin fails++; $display("FAIL b2b_head%0d got %h/%h want %h/%h", i, ifc.out_pc, ifc.out_instr, head().pc, head().instr); end
    end
    drive(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_flush();
    drive(0, 1, 32'h3200, 32'h1111_1111, 0, 0);
    drive(0, 1, 32'h3204, 32'h2222_2222, 0, 0);
    drive(0, 1, 32'h3208, 32'h3333_3333, 1, 1);
    tests++; if (ifc.count !== '0) begin fails++; $display("FAIL flush_count got %0d want 0", ifc.count); end
    tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b want 0", ifc.out_valid); end
    tests++;
    if (ifc.out_pc !== 32'h0 || ifc.out_instr !== 32'h0 || ifc.out_adel !== 1'b0)
      begin fails++; $display("FAIL flush_zero got %h/%h/%0b want 0/0/0", ifc.out_pc, ifc.out_instr, ifc.out_adel); end
    tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %0b want 1", ifc.in_ready); end
    drive(0, 1, 32'h3300, 32'h4444_4444, 0, 0);
    tests++; if (ifc.out_pc !== 32'h3300 || int'(ifc.count) != 1) begin fails++; $display("FAIL flush_after got %h want 3300", ifc.out_pc); end
    drive(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_adel();
    logic [31:0] pcs [4];
    pcs = '{32'h3002, 32'h2FFC, 32'h7000, 32'h6FFC};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, pcs[i], 32'hDEAD_BEE0 + 32'(i), 0, 0);
      tests++; if (ifc.out_adel !== head().adel) begin fails++; $display("FAIL adel_flag%0d got %0b want %0b", i, ifc.out_adel, head().adel); end
      tests++; if (ifc.out_instr !== head().instr) begin fails++; $display("FAIL adel_instr%0d got %h want %h", i, ifc.out_instr, head().instr); end
      tests++; if (ifc.out_pc !== pcs[i]) begin fails++; $display("FAIL adel_pc%0d got %h want %h", i, ifc.out_pc, pcs[i]); end
      drive(0, 0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 32'h3400, 32'h5555_5555, 0, 0);
    drive(0, 1, 32'h3404, 32'h6666_6666, 0, 0);
    drive(1, 1, 32'h3408, 32'h7777_7777, 0, 0);
    tests++; if (ifc.count !== '0) begin fails++; $display("FAIL rstmid_count got %0d want 0", ifc.count); end
    tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %0b want 0", ifc.out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int i = 0; i < 300; i++) begin
      pc = 32'h2FF0 + 32'($urandom_range(0, 16'h4020));
      drive(0, 1'($urandom_range(0, 1)), pc, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
      tests++;
      if (int'(ifc.count) != sb.size() || ifc.out_pc !== head().pc || ifc.out_instr !== head().instr ||
          ifc.out_adel !== head().adel || ifc.out_valid !== (sb.size() > 0))
        begin fails++; $display("FAIL rand%0d got cnt=%0d pc=%h ins=%h adel=%0b want cnt=%0d pc=%h ins=%h adel=%0b",
          i, ifc.count, ifc.out_pc, ifc.out_instr, ifc.out_adel, sb.size(), head().pc, head().instr, head().adel); end
    end
  endtask

  initial begin
    ifc.in_valid = 0; ifc.in_pc = 0; ifc.in_instr = 0; ifc.out_ready = 0; ifc.flush = 0;
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_flush();
    test_adel();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
